// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the iterative 32-point FFT core.
// Used by the stage sequencer and its pass timer.
package fft_pkg;

  localparam int NO_IN_OUT      = 32;
  localparam int DATA_WIDTH     = 16;
  localparam int DEF_NO_STAGES  = 5;
  localparam int DEF_STAGE_W    = 3;
  localparam int LAT_W          = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUT     = 2'd2
  } state_e;

endpackage

// File: rtl/fft_pass_timer.sv
// Per-pass latency counter and stage index for the reused butterfly array.
// Flags the final cycle of each pass and the last pass of a frame.
module fft_pass_timer
  import fft_pkg::*;
#(
  parameter int NO_STAGES = DEF_NO_STAGES,
  parameter int STAGE_W   = DEF_STAGE_W,
  parameter int BFLY_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_run,
  output logic [STAGE_W-1:0] o_stage,
  output logic               o_pass_done,
  output logic               o_last_stage
);

  logic [LAT_W-1:0]   r_lat_cnt;
  logic [STAGE_W-1:0] r_stage;
  logic               w_lat_end;

  assign w_lat_end    = (r_lat_cnt == LAT_W'(BFLY_LAT - 1));
  assign o_last_stage = (r_stage == STAGE_W'(NO_STAGES - 1));
  assign o_pass_done  = i_run && w_lat_end;
  assign o_stage      = r_stage;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
      r_stage   <= '0;
    end else if (i_clear) begin
      r_lat_cnt <= '0;
      r_stage   <= '0;
    end else if (i_run) begin
      if (w_lat_end) begin
        r_lat_cnt <= '0;
        r_stage   <= o_last_stage ? '0 : r_stage + STAGE_W'(1);
      end else begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control FSM for the iterative FFT: loads a frame, steps the stage index
// through every pass, then hands the result downstream over valid/ready.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int NO_STAGES = DEF_NO_STAGES,
  parameter int STAGE_W   = DEF_STAGE_W,
  parameter int BFLY_LAT  = 1,
  parameter int FCNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               load_sel,
  output logic               reg_en,
  output logic [STAGE_W-1:0] stage_sel,
  output logic               busy,
  output logic [FCNT_W-1:0]  frame_cnt
);

  state_e              r_state;
  logic [FCNT_W-1:0]   r_frame_cnt;

  logic                w_accept;
  logic                w_handoff;
  logic                w_pass_done;
  logic                w_last_stage;
  logic                w_timer_clear;
  logic                w_timer_run;
  logic [STAGE_W-1:0]  w_stage;

  assign w_timer_clear = flush || w_accept;
  assign w_timer_run   = (r_state == COMPUTE);
  assign frame_cnt     = r_frame_cnt;

  fft_pass_timer #(
    .NO_STAGES (NO_STAGES),
    .STAGE_W   (STAGE_W),
    .BFLY_LAT  (BFLY_LAT)
  ) u_pass_timer (
    .clk          (CLK),
    .rst_n        (RST),
    .i_clear      (w_timer_clear),
    .i_run        (w_timer_run),
    .o_stage      (w_stage),
    .o_pass_done  (w_pass_done),
    .o_last_stage (w_last_stage)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    w_accept  = 1'b0;
    w_handoff = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_sel  = 1'b0;
    reg_en    = 1'b0;
    stage_sel = '0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = !flush;
        w_accept = in_valid && !flush;
      end
      COMPUTE: begin
        busy      = 1'b1;
        stage_sel = w_stage;
        reg_en    = w_pass_done && !flush;
      end
      OUT: begin
        // A new frame may only enter while the finished one is leaving.
        out_valid = !flush;
        in_ready  = out_ready && !flush;
        w_handoff = out_ready && !flush;
        w_accept  = w_handoff && in_valid;
      end
      default: ;
    endcase
    load_sel = w_accept;
    reg_en   = reg_en || w_accept;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) r_state <= COMPUTE;
        end
        COMPUTE: begin
          if (w_pass_done && w_last_stage) r_state <= OUT;
        end
        OUT: begin
          if (w_handoff) begin
            r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            r_state     <= w_accept ? COMPUTE : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
